// File: rtl/iis_pkg.sv
// Shared types for the iis rx pattern checker: FSM states, pattern phase
// and default widths.
package iis_pkg;

  localparam int DEF_DW  = 32;
  localparam int DEF_ECW = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LOCKED
  } state_e;

  typedef enum logic {
    PH_A,
    PH_B
  } phase_e;

  function automatic phase_e flip_phase(input phase_e p);
    return (p == PH_A) ? PH_B : PH_A;
  endfunction

endpackage

// File: rtl/iis_pair_cmp.sv
// Masked compare of a left/right word pair against pattern A and its
// complement B; a frame is in a phase only if both sides agree.
module iis_pair_cmp #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] l,
  input  logic [DW-1:0] r,
  input  logic [DW-1:0] pat_l,
  input  logic [DW-1:0] pat_r,
  input  logic [DW-1:0] mask,
  output logic          match_a,
  output logic          match_b
);

  always_comb begin
    match_a = (((l ^ pat_l) & mask) == '0) && (((r ^ pat_r) & mask) == '0);
    match_b = (((l ^ ~pat_l) & mask) == '0) && (((r ^ ~pat_r) & mask) == '0);
  end

endmodule

// File: rtl/iis_rx_checker.sv
// Drains left/right pairs from the iis rx FIFOs and qualifies them against an
// alternating A / ~A pattern, tracking lock, frame and error counts.
module iis_rx_checker
  import iis_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3,
  parameter int ECW    = DEF_ECW
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           enable,
  input  logic           clear,
  input  logic [DW-1:0]  pat_l,
  input  logic [DW-1:0]  pat_r,
  input  logic [DW-1:0]  data_mask,
  input  logic [DW-1:0]  rx_data_l,
  input  logic [DW-1:0]  rx_data_r,
  input  logic           rx_data_l_empty,
  input  logic           rx_data_r_empty,
  output logic           rx_data_drain,
  output logic           locked,
  output logic           err_sticky,
  output logic [31:0]    frame_count,
  output logic [ECW-1:0] error_count
);

  localparam int RW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(LOSS_N + 1);

  state_e         state_q, state_d;
  phase_e         phase_q, phase_d;
  logic [RW-1:0]  run_q, run_d;
  logic [MW-1:0]  miss_q, miss_d;
  logic           drain_q, drain_d;
  logic           locked_q, locked_d;
  logic           sticky_q, sticky_d;
  logic [31:0]    frames_q, frames_d;
  logic [ECW-1:0] errors_q, errors_d;

  logic match_a, match_b, match_exp, pop;

  iis_pair_cmp #(.DW(DW)) u_cmp (
    .l       (rx_data_l),
    .r       (rx_data_r),
    .pat_l   (pat_l),
    .pat_r   (pat_r),
    .mask    (data_mask),
    .match_a (match_a),
    .match_b (match_b)
  );

  // Pops are gated by state so nothing drains while in reset or IDLE.
  assign pop = (state_q != IDLE) && enable && !clear &&
               !rx_data_l_empty && !rx_data_r_empty && !drain_q;
  assign match_exp = (phase_q == PH_A) ? match_a : match_b;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    run_d    = run_q;
    miss_d   = miss_q;
    drain_d  = pop;
    locked_d = locked_q;
    sticky_d = sticky_q;
    frames_d = frames_q;
    errors_d = errors_q;

    if (clear) begin
      state_d  = enable ? SEARCH : IDLE;
      phase_d  = PH_A;
      run_d    = '0;
      miss_d   = '0;
      locked_d = 1'b0;
      sticky_d = 1'b0;
      frames_d = '0;
      errors_d = '0;
    end else if (!enable) begin
      state_d  = IDLE;
      phase_d  = PH_A;
      run_d    = '0;
      miss_d   = '0;
      locked_d = 1'b0;
    end else begin
      if (state_q == IDLE) state_d = SEARCH;
      if (pop) begin
        frames_d = frames_q + 32'd1;
        if (state_q == SEARCH) begin
          // A broken run restarts from zero; the next frame seeds a new phase.
          if (run_q != '0 && !match_exp) begin
            run_d   = '0;
            phase_d = match_a ? PH_B : PH_A;
          end else if (run_q != '0) begin
            run_d   = run_q + RW'(1);
            phase_d = flip_phase(phase_q);
          end else if (match_a) begin
            run_d   = RW'(1);
            phase_d = PH_B;
          end else if (match_b) begin
            run_d   = RW'(1);
            phase_d = PH_A;
          end
          if (run_d == RW'(LOCK_N)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            run_d    = '0;
            miss_d   = '0;
          end
        end else if (state_q == LOCKED) begin
          phase_d = flip_phase(phase_q);
          if (match_exp) begin
            miss_d = '0;
          end else begin
            sticky_d = 1'b1;
            if (errors_q != '1) errors_d = errors_q + ECW'(1);
            if (miss_q + MW'(1) == MW'(LOSS_N)) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              miss_d   = '0;
              run_d    = '0;
              phase_d  = PH_A;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      phase_q  <= PH_A;
      run_q    <= '0;
      miss_q   <= '0;
      drain_q  <= 1'b0;
      locked_q <= 1'b0;
      sticky_q <= 1'b0;
      frames_q <= '0;
      errors_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      drain_q  <= drain_d;
      locked_q <= locked_d;
      sticky_q <= sticky_d;
      frames_q <= frames_d;
      errors_q <= errors_d;
    end
  end

  assign rx_data_drain = pop;
  assign locked        = locked_q;
  assign err_sticky    = sticky_q;
  assign frame_count   = frames_q;
  assign error_count   = errors_q;

endmodule

// File: doc/iis_rx_checker.md
Name: iis_rx_checker

Overview:
- Reader-side companion to the iis transceiver. Pops left/right word pairs from the iis rx FIFO through the drain handshake and checks them against an alternating pattern: word, then bitwise complement.
- Tracks pattern lock and counts frames and errors, so a bench or a BIST wrapper can qualify a link between a master and a slave iis instance.
- Sits beside iis in the clk domain and connects directly to the rx_data_* ports.

Parameters:
- DW, 32, data word width; must match the iis rx word width.
- LOCK_N, 4, consecutive matching frames needed to enter LOCKED.
- LOSS_N, 3, consecutive mismatching frames that drop LOCKED back to SEARCH.
- ECW, 16, error counter width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  checker enable; 0 forces IDLE and holds counters.
- clear  in  1  synchronous clear of counters, sticky flag and lock state.
- pat_l  in  DW  left-channel seed pattern A (B = ~A).
- pat_r  in  DW  right-channel seed pattern A (B = ~A).
- data_mask  in  DW  1 = bit is compared; supports short words.
- rx_data_l  in  DW  left word at FIFO head.
- rx_data_r  in  DW  right word at FIFO head.
- rx_data_l_empty  in  1  left FIFO empty.
- rx_data_r_empty  in  1  right FIFO empty.
- rx_data_drain  out  1  one-cycle pop pulse to both FIFOs.
- locked  out  1  pattern lock achieved.
- err_sticky  out  1  set on any mismatch while locked.
- frame_count  out  32  frames popped while enabled (wraps).
- error_count  out  ECW  mismatching frames while locked (saturates).

Behaviour:
- Reset values: rx_data_drain=0, locked=0, err_sticky=0, frame_count=0, error_count=0. FSM resets to IDLE, expected phase to A, run counter to 0.
- FSM states: IDLE, SEARCH, LOCKED.
  - IDLE → SEARCH when enable=1.
  - Any state → IDLE when enable=0. Lock and phase are cleared; counters are held.
- Drain handshake:
  - Pop condition: enable=1, !rx_data_l_empty, !rx_data_r_empty, drain not asserted last cycle.
  - On the pop cycle: assert rx_data_drain for exactly one cycle and sample rx_data_l/rx_data_r in that same cycle (head data is valid while the FIFO is not empty).
  - Drain is always low on the cycle after a pop. Maximum rate is one frame per 2 clk.
  - One side empty → no pop; the checker waits for both sides.
- Compare:
  - A frame matches phase P when ((rx_l ^ P_l) & data_mask)==0 and ((rx_r ^ P_r) & data_mask)==0, with P_l = pat_l or ~pat_l, and likewise for P_r.
  - Left and right must be in the same phase.
- SEARCH:
  - Frame matches A → next expected phase is B, run+1.
  - Frame matches B → next expected phase is A, run+1.
  - Once run ≥ 1, a frame must match the expected phase; otherwise run=0 and the phase is re-derived from that frame.
  - A frame matching neither phase → run=0.
  - run reaches LOCK_N → LOCKED, locked=1, run=0.
- LOCKED:
  - Expected phase toggles every frame.
  - Match → miss run=0.
  - Mismatch → error_count+1 (saturates at all-ones), err_sticky=1, miss run+1. The expected phase still toggles.
  - Miss run reaches LOSS_N → SEARCH, locked=0. err_sticky and error_count are retained.
- frame_count increments on every pop in SEARCH or LOCKED and wraps at 2^32.
- Output registration: status outputs update the cycle after the pop cycle.
- clear=1 (synchronous, has priority over a pop in the same cycle):
  - Zeroes counters, err_sticky, lock and runs; goes to SEARCH if enable=1.
  - Suppresses drain while asserted.
- Pattern, mask and enable changes mid-stream take effect on the next pop. There is no retroactive check.
- Asynchronous reset mid-drain: drain drops immediately and no partial update occurs.

Decomposition:
- Package iis_pkg: state enum (IDLE, SEARCH, LOCKED), phase enum (PH_A, PH_B), default DW/ECW constants.
- One natural sub-module, iis_pair_cmp: combinational masked compare of (l, r) against pattern A and ~A; outputs match_a and match_b.
- The FSM, counters and drain logic live in the top module.

Test Plan:
- Lock on clean stream:
  - Stimulus: pat_l=32'hB77BEFDF, pat_r=32'hFBF7DEED, mask=all-ones; FIFO model feeds A,B,A,B… with both sides non-empty.
  - Response: drain pulses every 2 clk; locked=1 after the 4th pop; error_count=0; frame_count=N.
- Start in phase B:
  - Stimulus: first frame is ~A (32'h48841020/32'h04082112), then alternating.
  - Response: locked after 4 frames; no errors.
- Single bit flip while locked:
  - Stimulus: one frame with rx_l bit 0 flipped.
  - Response: error_count=1, err_sticky=1; locked stays 1; the next correct frames match.
- Loss of lock:
  - Stimulus: 3 consecutive all-zero frames while locked.
  - Response: locked=0 after the 3rd; error_count=3; relock after 4 good frames.
- Unbalanced FIFOs:
  - Stimulus: rx_data_l_empty=0, rx_data_r_empty=1 for 20 clk.
  - Response: rx_data_drain stays 0; pops resume within 1 clk of r becoming non-empty.
- Mask, clear and saturation:
  - Mask: data_mask=32'hFFFF0000 with low-half garbage → no errors.
  - Clear: a clear pulse mid-stream zeroes counters and gives no drain that cycle.
  - Saturation: ECW=4 with 20 bad frames while forced locked → error_count=15.
